mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts MIPS load/store requests from the datapath on a valid/ready handshake and drives the word-organised data RAM.
- RAM port behaviour: combinational read of the addressed word; write on the falling edge of clk.
- Handles byte/halfword addressing, big-endian lane selection, load sign/zero extension, and sub-word stores via read-modify-write.
- Flags misaligned or illegal requests without touching memory.

Parameters:
DATA_WIDTH, 32, word width; fixed at 32 for lane logic
ADDR_WIDTH, 10, RAM word-address width; byte address is ADDR_WIDTH+2 bits

Ports:
clk  input  1  clock, rising-edge FSM
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1=store, 0=load
req_op  input  3  size/sign code (see Behaviour)
req_addr  input  ADDR_WIDTH+2  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal op
mem_addr  output  ADDR_WIDTH  word address to RAM
mem_wdata  output  32  write data to RAM
mem_write  output  1  RAM write enable
mem_read  output  1  RAM read strobe
mem_rdata  input  32  RAM read data

Behaviour:
- Op codes:
  - Loads: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 011 SW.
  - Any other code is illegal.
- Lanes are big-endian: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16.
- Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=00.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
  - mem_write is gated combinationally by rst_n, so reset asserted during RMW_WR or STORE before the falling edge performs no write.
  - Latched request is discarded.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch we/op/addr/wdata.
  - Illegal op or misaligned -> RESP with err=1 and no memory cycle.
  - Load -> LOAD. SW -> STORE. SB/SH -> RMW_RD.
- req_ready=0 in every state except IDLE.
- mem_addr = latched addr[ADDR_WIDTH+1:2] throughout LOAD, STORE, RMW_RD, RMW_WR.
- LOAD:
  - mem_read=1.
  - At the rising edge, select the lane from mem_rdata and extend: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
  - Register the result into resp_rdata -> RESP.
- STORE: mem_write=1, mem_wdata=wdata (RAM writes on the falling edge) -> RESP.
- RMW_RD: mem_read=1; capture mem_rdata into the merge register and replace the target lane with wdata[7:0] (SB) or wdata[15:0] (SH) -> RMW_WR.
- RMW_WR: mem_write=1, mem_wdata=merge register -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - When resp_ready=1 at a rising edge -> IDLE, and resp_valid drops next cycle.
  - A new request is not accepted in the same cycle as the response handoff.
- Latency (accept edge to resp_valid):
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Then as long as resp_ready is held low.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- Address wrap: no special handling; the top byte-address bits map directly to the highest RAM word.

Test Plan:
1. Reset mid-operation: assert rst_n=0 during RMW_WR of SB -> RAM word unchanged, req_ready=1, all outputs 0.
2. Word round-trip: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after each accept.
3. Byte load extension: word 0x80FF7F01 at 0x020; LB 0x020 -> 0xFFFFFF80; LBU 0x020 -> 0x00000080; LB 0x022 -> 0x0000007F; LH 0x022 -> 0x00007F01; LHU 0x020 -> 0x000080FF.
4. Sub-word store: word 0x11223344 at 0x030; SB 0x031 data 0xAB -> word 0x11AB3344; then SH 0x032 data 0xCDEF -> 0x11ABCDEF. Response at 3 cycles, exactly one mem_write cycle each.
5. Misalignment: LW 0x011, SH 0x033, and illegal op 010 -> resp_err=1, resp_rdata=0, mem_read=mem_write=0 throughout, response after 1 cycle.
6. Backpressure: hold resp_ready=0 for 5 cycles after LW -> resp_valid and resp_rdata stable, req_ready=0, a queued req_valid is not accepted until the cycle after the handoff.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS load/store initiator for a word-organised data RAM
// Big-endian lanes, load extension, and sub-word stores by read-modify-write.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    mem_write_c;

    logic                    op_legal;
    logic                    aligned;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Stores only support the unsigned-free size codes; loads add LBU/LHU.
    always_comb begin
        op_legal = 1'b0;
        if (req_we) begin
            op_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b011);
        end else begin
            op_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b011) ||
                       (req_op == 3'b100) || (req_op == 3'b101);
        end
    end

    always_comb begin
        aligned = 1'b1;
        case (req_op[1:0])
            2'b01:   aligned = (req_addr[0] == 1'b0);
            2'b11:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        lane_byte = mem_rdata[31:24];
        case (addr_q[1:0])
            2'b00:   lane_byte = mem_rdata[31:24];
            2'b01:   lane_byte = mem_rdata[23:16];
            2'b10:   lane_byte = mem_rdata[15:8];
            default: lane_byte = mem_rdata[7:0];
        endcase
        lane_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        load_ext = mem_rdata;
        case (op_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_read    = 1'b0;
        mem_write_c = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = !(op_legal && aligned);
                    if (!(op_legal && aligned)) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_op == 3'b011) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end

            S_LOAD: begin
                mem_read = 1'b1;
                mem_addr = addr_q[ADDR_WIDTH+1:2];
                rdata_d  = load_ext;
                state_d  = S_RESP;
            end

            S_STORE: begin
                mem_write_c = 1'b1;
                mem_addr    = addr_q[ADDR_WIDTH+1:2];
                mem_wdata   = wdata_q;
                state_d     = S_RESP;
            end

            S_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = addr_q[ADDR_WIDTH+1:2];
                merge_d  = mem_rdata;
                if (op_q[0]) begin
                    if (addr_q[1]) merge_d[15:0]  = wdata_q[15:0];
                    else           merge_d[31:16] = wdata_q[15:0];
                end else begin
                    case (addr_q[1:0])
                        2'b00:   merge_d[31:24] = wdata_q[7:0];
                        2'b01:   merge_d[23:16] = wdata_q[7:0];
                        2'b10:   merge_d[15:8]  = wdata_q[7:0];
                        default: merge_d[7:0]   = wdata_q[7:0];
                    endcase
                end
                state_d = S_RMW_WR;
            end

            S_RMW_WR: begin
                mem_write_c = 1'b1;
                mem_addr    = addr_q[ADDR_WIDTH+1:2];
                mem_wdata   = merge_q;
                state_d     = S_RESP;
            end

            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The RAM writes on the falling edge, so gating by rst_n aborts a pending write.
    assign mem_write  = mem_write_c & rst_n;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:1023];
    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(negedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE, measures latency and memory activity, then hands off.
    task automatic transact(input string tag, input logic we, input logic [2:0] op,
                            input logic [11:0] addr, input logic [31:0] wd,
                            input int exp_lat, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_writes, input int exp_reads);
        int lat;
        int writes;
        int reads;
        int both;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        lat = 1; writes = 0; reads = 0; both = 0;
        while (!resp_valid && lat < 20) begin
            writes += int'(mem_write);
            reads  += int'(mem_read);
            both   += int'(mem_write & mem_read);
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "_writes"}, writes, exp_writes);
        check({tag, "_reads"}, reads, exp_reads);
        check({tag, "_rw_excl"}, both, 0);
        check({tag, "_resp_noacc"}, {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #1;
        check("rst_ready",  {31'd0, req_ready},  32'd1);
        check("rst_valid",  {31'd0, resp_valid}, 32'd0);
        check("rst_err",    {31'd0, resp_err},   32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        check("rst_mwrite", {31'd0, mem_write},  32'd0);
        check("rst_mread",  {31'd0, mem_read},   32'd0);
        check("rst_maddr",  {22'd0, mem_addr},   32'd0);
        check("rst_mwdata", mem_wdata,           32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset during RMW_WR of an SB must leave the RAM word untouched.
        transact("pre40", 1'b1, 3'b011, 12'h040, 32'h55667788, 2, 32'h0, 1'b0, 1, 0);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 12'h041; req_wdata = 32'h000000AA;
        step();
        req_valid = 1'b0;
        step();
        check("mid_in_rmwwr", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_ready",  {31'd0, req_ready},  32'd1);
        check("mid_valid",  {31'd0, resp_valid}, 32'd0);
        check("mid_mwrite", {31'd0, mem_write},  32'd0);
        check("mid_mread",  {31'd0, mem_read},   32'd0);
        check("mid_maddr",  {22'd0, mem_addr},   32'd0);
        check("mid_mwdata", mem_wdata,           32'd0);
        check("mid_rdata",  resp_rdata,          32'd0);
        step();
        check("mid_ram", ram[16], 32'h55667788);
        rst_n = 1'b1;
        step();
        transact("lw40", 1'b0, 3'b011, 12'h040, 32'h0, 2, 32'h55667788, 1'b0, 0, 1);

        // Word round trip.
        transact("sw10", 1'b1, 3'b011, 12'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 0);
        check("sw10_ram", ram[4], 32'hDEADBEEF);
        transact("lw10", 1'b0, 3'b011, 12'h010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 1);

        // Load lane selection and extension.
        transact("sw20",  1'b1, 3'b011, 12'h020, 32'h80FF7F01, 2, 32'h0, 1'b0, 1, 0);
        transact("lb20",  1'b0, 3'b000, 12'h020, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 1);
        transact("lbu20", 1'b0, 3'b100, 12'h020, 32'h0, 2, 32'h00000080, 1'b0, 0, 1);
        transact("lb22",  1'b0, 3'b000, 12'h022, 32'h0, 2, 32'h0000007F, 1'b0, 0, 1);
        transact("lb23",  1'b0, 3'b000, 12'h023, 32'h0, 2, 32'h00000001, 1'b0, 0, 1);
        transact("lh22",  1'b0, 3'b001, 12'h022, 32'h0, 2, 32'h00007F01, 1'b0, 0, 1);
        transact("lh20",  1'b0, 3'b001, 12'h020, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0, 1);
        transact("lhu20", 1'b0, 3'b101, 12'h020, 32'h0, 2, 32'h000080FF, 1'b0, 0, 1);

        // Sub-word stores via read-modify-write.
        transact("sw30", 1'b1, 3'b011, 12'h030, 32'h11223344, 2, 32'h0, 1'b0, 1, 0);
        transact("sb31", 1'b1, 3'b000, 12'h031, 32'hFFFFFFAB, 3, 32'h0, 1'b0, 1, 1);
        check("sb31_ram", ram[12], 32'h11AB3344);
        transact("sh32", 1'b1, 3'b001, 12'h032, 32'h1234CDEF, 3, 32'h0, 1'b0, 1, 1);
        check("sh32_ram", ram[12], 32'h11ABCDEF);
        transact("sh30", 1'b1, 3'b001, 12'h030, 32'h00009876, 3, 32'h0, 1'b0, 1, 1);
        transact("sb33", 1'b1, 3'b000, 12'h033, 32'h00000042, 3, 32'h0, 1'b0, 1, 1);
        transact("lw30", 1'b0, 3'b011, 12'h030, 32'h0, 2, 32'h9876CD42, 1'b0, 0, 1);

        // Misaligned and illegal requests never reach memory.
        transact("lw11",  1'b0, 3'b011, 12'h011, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        transact("sh33",  1'b1, 3'b001, 12'h033, 32'h0000FFFF, 1, 32'h0, 1'b1, 0, 0);
        transact("op010", 1'b0, 3'b010, 12'h010, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        transact("sop100", 1'b1, 3'b100, 12'h010, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        check("err_ram", ram[4], 32'hDEADBEEF);

        // Highest word via top address bits.
        transact("swtop", 1'b1, 3'b011, 12'hFFC, 32'hA5A5C3C3, 2, 32'h0, 1'b0, 1, 0);
        check("swtop_ram", ram[1023], 32'hA5A5C3C3);

        // Backpressure with a queued request.
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b011; req_addr = 12'h010; req_wdata = 32'h0;
        step();
        req_addr = 12'h020;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'hDEADBEEF);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_hand_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_hand_ready", {31'd0, req_ready},  32'd1);
        step();
        req_valid = 1'b0;
        check("bp_acc_ready", {31'd0, req_ready}, 32'd0);
        check("bp_acc_read",  {31'd0, mem_read},  32'd1);
        check("bp_acc_addr",  {22'd0, mem_addr},  32'd8);
        step();
        check("bp2_valid", {31'd0, resp_valid}, 32'd1);
        check("bp2_rdata", resp_rdata, 32'h80FF7F01);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp2_drop", {31'd0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
